// File: rtl/dmem_arbiter_pkg.sv
// Shared types and defaults for the data-memory arbiter: request/response
// bundles, the default aging limit and the grant encoding.
package dmem_arbiter_pkg;

  localparam int DMEM_ADDR_W      = 32;
  localparam int DMEM_DATA_W      = 32;
  localparam int DEFAULT_MAX_WAIT = 4;
  localparam int DEFAULT_CNT_W    = 8;

  typedef struct packed {
    logic                   valid;
    logic                   write;
    logic [DMEM_ADDR_W-1:0] addr;
    logic [DMEM_DATA_W-1:0] wdata;
  } dmem_req_s;

  typedef struct packed {
    logic                   valid;
    logic [DMEM_DATA_W-1:0] rdata;
  } dmem_rsp_s;

  typedef enum logic [1:0] {
    GRANT_NONE = 2'd0,
    GRANT_P0   = 2'd1,
    GRANT_P1   = 2'd2
  } grant_e;

endpackage

// File: rtl/arb_age_counter.sv
// Saturating wait counter for the low-priority port; expired flags that the
// port has lost arbitration MAX_WAIT cycles in a row.
module arb_age_counter
  import dmem_arbiter_pkg::*;
#(
  parameter int MAX_WAIT = DEFAULT_MAX_WAIT,
  parameter int CNT_W    = DEFAULT_CNT_W
) (
  input  logic clk,
  input  logic rst,
  input  logic inc,
  input  logic clr,
  output logic expired
);

  localparam logic [CNT_W-1:0] LIMIT = CNT_W'(MAX_WAIT);

  logic [CNT_W-1:0] cnt;

  // Clear takes precedence so a grant in the same cycle as a loss never ages.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (inc && (cnt < LIMIT)) begin
      cnt <= cnt + CNT_W'(1);
    end
  end

  assign expired = (cnt >= LIMIT);

endmodule

// File: rtl/dmem_arbiter.sv
// Two-port arbiter in front of the single-port data memory: port 0 (pipeline)
// has priority, port 1 (loader) wins after aging out. Responses are registered.
module dmem_arbiter
  import dmem_arbiter_pkg::*;
#(
  parameter int ADDR_W   = DMEM_ADDR_W,
  parameter int DATA_W   = DMEM_DATA_W,
  parameter int MAX_WAIT = DEFAULT_MAX_WAIT,
  parameter int CNT_W    = DEFAULT_CNT_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req0_valid,
  input  logic              req0_write,
  input  logic [ADDR_W-1:0] req0_addr,
  input  logic [DATA_W-1:0] req0_wdata,
  output logic              req0_ready,
  output logic              rsp0_valid,
  output logic [DATA_W-1:0] rsp0_rdata,
  output logic              stall0,
  input  logic              req1_valid,
  input  logic              req1_write,
  input  logic [ADDR_W-1:0] req1_addr,
  input  logic [DATA_W-1:0] req1_wdata,
  output logic              req1_ready,
  output logic              rsp1_valid,
  output logic [DATA_W-1:0] rsp1_rdata,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic              mem_we,
  input  logic [DATA_W-1:0] mem_rdata
);

  grant_e grant;
  logic   aged;
  logic   rsp0_valid_q;
  logic   rsp1_valid_q;

  arb_age_counter #(
    .MAX_WAIT (MAX_WAIT),
    .CNT_W    (CNT_W)
  ) u_age (
    .clk     (clk),
    .rst     (rst),
    .inc     (req1_valid & ~req1_ready),
    .clr     (~req1_valid | req1_ready),
    .expired (aged)
  );

  // Port 1 only beats a concurrent port 0 request once it has aged out.
  always_comb begin
    grant = GRANT_NONE;
    if (!rst) begin
      if (req1_valid && (!req0_valid || aged)) begin
        grant = GRANT_P1;
      end else if (req0_valid) begin
        grant = GRANT_P0;
      end
    end
  end

  assign req0_ready = (grant == GRANT_P0);
  assign req1_ready = (grant == GRANT_P1);
  assign stall0     = req0_valid & ~req0_ready;

  always_comb begin
    mem_addr  = '0;
    mem_wdata = '0;
    mem_we    = 1'b0;
    case (grant)
      GRANT_P0: begin
        mem_addr  = req0_addr;
        mem_wdata = req0_wdata;
        mem_we    = req0_write;
      end
      GRANT_P1: begin
        mem_addr  = req1_addr;
        mem_wdata = req1_wdata;
        mem_we    = req1_write;
      end
      default: ;
    endcase
  end

  // Stores only acknowledge; rdata keeps the last load result.
  always_ff @(posedge clk) begin
    if (rst) begin
      rsp0_valid_q <= 1'b0;
      rsp1_valid_q <= 1'b0;
      rsp0_rdata   <= '0;
      rsp1_rdata   <= '0;
    end else begin
      rsp0_valid_q <= req0_ready;
      rsp1_valid_q <= req1_ready;
      if (req0_ready && !req0_write) begin
        rsp0_rdata <= mem_rdata;
      end
      if (req1_ready && !req1_write) begin
        rsp1_rdata <= mem_rdata;
      end
    end
  end

  // A response still pending when reset rises is dropped immediately.
  assign rsp0_valid = rsp0_valid_q & ~rst;
  assign rsp1_valid = rsp1_valid_q & ~rst;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Bench for dmem_arbiter: directed vector table, hand-written aging/reset
// sequences and a randomized phase checked against a behavioural model.
module tb_dmem_arbiter;

  localparam int MAX_WAIT = 4;

  logic        clk;
  logic        rst;
  logic        req0_valid, req0_write, req0_ready, rsp0_valid, stall0;
  logic [31:0] req0_addr, req0_wdata, rsp0_rdata;
  logic        req1_valid, req1_write, req1_ready, rsp1_valid;
  logic [31:0] req1_addr, req1_wdata, rsp1_rdata;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;
  logic        mem_we;

  int checks = 0;
  int errors = 0;

  // Behavioural model state
  int          m_wait;
  logic        m_rv0, m_rv1;
  logic [31:0] m_rd0, m_rd1;
  logic [31:0] ref_mem [256];
  logic        last_g0, last_g1;

  logic [31:0] sim_mem [256] = '{default: 32'h0};

  typedef struct {
    logic        rst;
    logic        v0;
    logic        w0;
    logic [31:0] a0;
    logic [31:0] d0;
    logic        v1;
    logic        w1;
    logic [31:0] a1;
    logic [31:0] d1;
    logic        e_r0;
    logic        e_r1;
    logic        e_st0;
    logic        e_we;
    logic        e_rv0;
    logic        e_rv1;
  } vec_t;

  vec_t vecs [8];

  dmem_arbiter #(
    .ADDR_W   (32),
    .DATA_W   (32),
    .MAX_WAIT (MAX_WAIT),
    .CNT_W    (8)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .req0_valid (req0_valid),
    .req0_write (req0_write),
    .req0_addr  (req0_addr),
    .req0_wdata (req0_wdata),
    .req0_ready (req0_ready),
    .rsp0_valid (rsp0_valid),
    .rsp0_rdata (rsp0_rdata),
    .stall0     (stall0),
    .req1_valid (req1_valid),
    .req1_write (req1_write),
    .req1_addr  (req1_addr),
    .req1_wdata (req1_wdata),
    .req1_ready (req1_ready),
    .rsp1_valid (rsp1_valid),
    .rsp1_rdata (rsp1_rdata),
    .mem_addr   (mem_addr),
    .mem_wdata  (mem_wdata),
    .mem_we     (mem_we),
    .mem_rdata  (mem_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Single-port memory: combinational read, write at the posedge
  assign mem_rdata = sim_mem[mem_addr[9:2]];
  always @(posedge clk) begin
    if (mem_we) sim_mem[mem_addr[9:2]] <= mem_wdata;
  end

  task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, actual, expected, $time);
    end
  endtask

  task automatic applyStimulus(input logic r, input logic v0, input logic w0, input logic [31:0] a0,
                               input logic [31:0] d0, input logic v1, input logic w1,
                               input logic [31:0] a1, input logic [31:0] d1);
    rst        = r;
    req0_valid = v0;
    req0_write = w0;
    req0_addr  = a0;
    req0_wdata = d0;
    req1_valid = v1;
    req1_write = w1;
    req1_addr  = a1;
    req1_wdata = d1;
  endtask

  // Check this cycle against the model, then advance the model past the posedge
  task automatic modelStep();
    logic        g0, g1, ewe;
    logic [31:0] ea, ed;
    g0 = 1'b0;
    g1 = 1'b0;
    if (!rst) begin
      if (req0_valid && req1_valid) begin
        g1 = (m_wait >= MAX_WAIT);
        g0 = !g1;
      end else begin
        g0 = req0_valid;
        g1 = req1_valid;
      end
    end
    ea  = g0 ? req0_addr  : (g1 ? req1_addr  : 32'h0);
    ed  = g0 ? req0_wdata : (g1 ? req1_wdata : 32'h0);
    ewe = g0 ? req0_write : (g1 ? req1_write : 1'b0);
    checkOutput("m.ready0", 64'(req0_ready), 64'(g0));
    checkOutput("m.ready1", 64'(req1_ready), 64'(g1));
    checkOutput("m.stall0", 64'(stall0), 64'(req0_valid && !g0));
    checkOutput("m.mem_we", 64'(mem_we), 64'(ewe));
    checkOutput("m.mem_addr", 64'(mem_addr), 64'(ea));
    checkOutput("m.mem_wdata", 64'(mem_wdata), 64'(ed));
    checkOutput("m.rsp0_valid", 64'(rsp0_valid), 64'(m_rv0 && !rst));
    checkOutput("m.rsp1_valid", 64'(rsp1_valid), 64'(m_rv1 && !rst));
    checkOutput("m.rsp0_rdata", 64'(rsp0_rdata), 64'(m_rd0));
    checkOutput("m.rsp1_rdata", 64'(rsp1_rdata), 64'(m_rd1));
    if (rst) begin
      m_wait = 0;
      m_rv0  = 1'b0;
      m_rv1  = 1'b0;
      m_rd0  = 32'h0;
      m_rd1  = 32'h0;
    end else begin
      m_rv0 = g0;
      m_rv1 = g1;
      if (g0 && !req0_write) m_rd0 = ref_mem[req0_addr[9:2]];
      if (g1 && !req1_write) m_rd1 = ref_mem[req1_addr[9:2]];
      if (g0 && req0_write) ref_mem[req0_addr[9:2]] = req0_wdata;
      if (g1 && req1_write) ref_mem[req1_addr[9:2]] = req1_wdata;
      if (!req1_valid || g1) m_wait = 0;
      else if (m_wait < MAX_WAIT) m_wait = m_wait + 1;
    end
    last_g0 = g0;
    last_g1 = g1;
  endtask

  task automatic finishCycle();
    @(posedge clk);
    #1;
  endtask

  // Both ports issue loads; check only whether port 1 wins this cycle
  task automatic contendCycle(input string name, input logic exp_r1);
    applyStimulus(1'b0, 1'b1, 1'b0, 32'h10, 32'h0, 1'b1, 1'b0, 32'h80, 32'h0);
    @(negedge clk);
    checkOutput(name, 64'(req1_ready), 64'(exp_r1));
    checkOutput({name, ".stall0"}, 64'(stall0), 64'(exp_r1));
    modelStep();
    finishCycle();
  endtask

  task automatic idleCycle(input logic r);
    applyStimulus(r, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0);
    @(negedge clk);
    modelStep();
    finishCycle();
  endtask

  initial begin
    logic        hv0, hw0, hv1, hw1, r;
    logic [31:0] ha0, hd0, ha1, hd1;

    for (int i = 0; i < 256; i++) ref_mem[i] = 32'h0;
    m_wait  = 0;
    m_rv0   = 1'b0;
    m_rv1   = 1'b0;
    m_rd0   = 32'h0;
    m_rd1   = 32'h0;
    last_g0 = 1'b0;
    last_g1 = 1'b0;

    //            rst  v0  w0  a0      d0            v1  w1  a1      d1            r0  r1  st0 we  rv0 rv1
    vecs[0] = '{1'b1, 1'b1, 1'b0, 32'h00, 32'h0,        1'b1, 1'b0, 32'h00, 32'h0,        1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
    vecs[1] = '{1'b1, 1'b1, 1'b0, 32'h00, 32'h0,        1'b1, 1'b0, 32'h00, 32'h0,        1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
    vecs[2] = '{1'b0, 1'b1, 1'b0, 32'h00, 32'h0,        1'b1, 1'b0, 32'h00, 32'h0,        1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
    vecs[3] = '{1'b0, 1'b1, 1'b1, 32'h40, 32'hDEADBEEF, 1'b0, 1'b0, 32'h00, 32'h0,        1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0};
    vecs[4] = '{1'b0, 1'b1, 1'b0, 32'h40, 32'h0,        1'b0, 1'b0, 32'h00, 32'h0,        1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
    vecs[5] = '{1'b0, 1'b0, 1'b0, 32'h00, 32'h0,        1'b1, 1'b1, 32'h80, 32'h12345678, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0};
    vecs[6] = '{1'b0, 1'b0, 1'b0, 32'h00, 32'h0,        1'b1, 1'b0, 32'h80, 32'h0,        1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1};
    vecs[7] = '{1'b0, 1'b0, 1'b0, 32'h00, 32'h0,        1'b0, 1'b0, 32'h00, 32'h0,        1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};

    applyStimulus(1'b1, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0);
    finishCycle();

    for (int i = 0; i < 8; i++) begin
      applyStimulus(vecs[i].rst, vecs[i].v0, vecs[i].w0, vecs[i].a0, vecs[i].d0,
                    vecs[i].v1, vecs[i].w1, vecs[i].a1, vecs[i].d1);
      @(negedge clk);
      checkOutput($sformatf("vec%0d.ready0", i), 64'(req0_ready), 64'(vecs[i].e_r0));
      checkOutput($sformatf("vec%0d.ready1", i), 64'(req1_ready), 64'(vecs[i].e_r1));
      checkOutput($sformatf("vec%0d.stall0", i), 64'(stall0), 64'(vecs[i].e_st0));
      checkOutput($sformatf("vec%0d.mem_we", i), 64'(mem_we), 64'(vecs[i].e_we));
      checkOutput($sformatf("vec%0d.rsp0_valid", i), 64'(rsp0_valid), 64'(vecs[i].e_rv0));
      checkOutput($sformatf("vec%0d.rsp1_valid", i), 64'(rsp1_valid), 64'(vecs[i].e_rv1));
      if (i == 5) checkOutput("vec5.rsp0_rdata", 64'(rsp0_rdata), 64'h0000_0000_DEAD_BEEF);
      if (i == 7) checkOutput("vec7.rsp1_rdata", 64'(rsp1_rdata), 64'h0000_0000_1234_5678);
      modelStep();
      finishCycle();
    end

    // Continuous contention: port 1 wins every fifth cycle
    for (int i = 0; i < 10; i++) begin
      contendCycle($sformatf("contend%0d.ready1", i), (i % 5) == 4);
    end
    idleCycle(1'b0);

    // Port 1 withdraws after three losses; its wait restarts from zero
    for (int i = 0; i < 3; i++) contendCycle($sformatf("drop%0d.ready1", i), 1'b0);
    applyStimulus(1'b0, 1'b1, 1'b0, 32'h10, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0);
    @(negedge clk);
    modelStep();
    finishCycle();
    for (int i = 0; i < 5; i++) contendCycle($sformatf("rereq%0d.ready1", i), i == 4);
    idleCycle(1'b0);

    // Reset while a port 1 load response is pending
    applyStimulus(1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b1, 1'b0, 32'h80, 32'h0);
    @(negedge clk);
    checkOutput("rstpend.ready1", 64'(req1_ready), 64'h1);
    modelStep();
    finishCycle();
    applyStimulus(1'b1, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0);
    @(negedge clk);
    checkOutput("rstpend.rsp1_valid_T1", 64'(rsp1_valid), 64'h0);
    modelStep();
    finishCycle();
    applyStimulus(1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0);
    @(negedge clk);
    checkOutput("rstpend.rsp1_valid_T2", 64'(rsp1_valid), 64'h0);
    modelStep();
    finishCycle();

    // Aged counter is cleared by reset: port 1 waits a full round again
    for (int i = 0; i < 3; i++) contendCycle($sformatf("preage%0d.ready1", i), 1'b0);
    applyStimulus(1'b1, 1'b1, 1'b0, 32'h10, 32'h0, 1'b1, 1'b0, 32'h80, 32'h0);
    @(negedge clk);
    checkOutput("agerst.mem_addr", 64'(mem_addr), 64'h0);
    modelStep();
    finishCycle();
    for (int i = 0; i < 5; i++) contendCycle($sformatf("postrst%0d.ready1", i), i == 4);

    // Randomized traffic; stalled requesters hold their request stable
    hv0 = 1'b0; hw0 = 1'b0; ha0 = 32'h0; hd0 = 32'h0;
    hv1 = 1'b0; hw1 = 1'b0; ha1 = 32'h0; hd1 = 32'h0;
    for (int n = 0; n < 400; n++) begin
      r = ($urandom_range(0, 39) == 0);
      if (!(hv0 && !last_g0) || r) begin
        hv0 = ($urandom_range(0, 3) != 0);
        hw0 = $urandom_range(0, 1) == 1;
        ha0 = 32'($urandom_range(0, 15)) << 2;
        hd0 = $urandom;
      end
      if (!(hv1 && !last_g1) || r) begin
        hv1 = ($urandom_range(0, 2) != 0);
        hw1 = $urandom_range(0, 1) == 1;
        ha1 = 32'($urandom_range(0, 15)) << 2;
        hd1 = $urandom;
      end
      applyStimulus(r, hv0, hw0, ha0, hd0, hv1, hw1, ha1, hd1);
      @(negedge clk);
      modelStep();
      finishCycle();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
